// File: rtl/accu_sched.sv
// Round-robin job scheduler feeding one shared pipelined accumulator.
// Zero-size jobs and a hung accumulator are resolved here.
module accu_sched #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            job_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] job_size,
   output logic [NUM_REQ-1:0]            job_ready,
   input  logic [NUM_REQ-1:0]            in_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
   output logic [NUM_REQ-1:0]            in_ready,
   output logic [DATA_WIDTH-1:0]         accu_size,
   output logic                          accu_inc,
   output logic [DATA_WIDTH-1:0]         accu_array,
   input  logic [DATA_WIDTH-1:0]         accu_res,
   input  logic                          accu_ready,
   output logic [NUM_REQ-1:0]            res_valid,
   output logic [DATA_WIDTH-1:0]         res_data,
   output logic                          busy,
   output logic                          err
);

   localparam int IW = $clog2(NUM_REQ);
   localparam logic [DATA_WIDTH-1:0] TO_LAST = DATA_WIDTH'(TIMEOUT - 1);
   localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      WAIT
   } state_t;

   state_t                 state;
   logic [IW-1:0]          ptr;
   logic [IW-1:0]          owner;
   logic [IW-1:0]          win;
   logic [IW-1:0]          cand;
   logic                   found;
   logic                   accept;
   logic                   beat;
   logic                   last_beat;
   logic [DATA_WIDTH-1:0]  size_q;
   logic [DATA_WIDTH-1:0]  sent_cnt;
   logic [DATA_WIDTH-1:0]  wait_cnt;
   logic [DATA_WIDTH-1:0]  win_size;
   logic [DATA_WIDTH-1:0]  own_data;

   // Search starts just past the last winner, wrapping modulo NUM_REQ.
   always_comb begin
      win   = ptr;
      cand  = ptr;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IW'((int'(ptr) + k) % NUM_REQ);
         if (!found && job_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign win_size  = job_size[int'(win)*DATA_WIDTH +: DATA_WIDTH];
   assign own_data  = in_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
   assign accept    = rst && (state == IDLE) && found;
   assign beat      = rst && (state == RUN) && in_valid[owner];
   assign last_beat = beat && (sent_cnt == size_q - ONE);

   always_comb begin
      job_ready = '0;
      in_ready  = '0;
      if (accept) begin
         job_ready[win] = 1'b1;
      end
      if (rst && state == RUN) begin
         in_ready[owner] = 1'b1;
      end
   end

   assign accu_inc   = beat;
   assign accu_array = beat ? own_data : '0;
   assign accu_size  = size_q;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= IW'(NUM_REQ - 1);
         owner     <= '0;
         size_q    <= '0;
         sent_cnt  <= '0;
         wait_cnt  <= '0;
         res_valid <= '0;
         res_data  <= '0;
         err       <= 1'b0;
      end else begin
         res_valid <= '0;
         res_data  <= '0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  ptr <= win;
                  // A zero count would wrap the accumulator compare.
                  if (win_size == '0) begin
                     res_valid[win] <= 1'b1;
                  end else begin
                     owner    <= win;
                     size_q   <= win_size;
                     sent_cnt <= '0;
                     state    <= RUN;
                  end
               end
            end
            RUN: begin
               if (beat) begin
                  sent_cnt <= sent_cnt + ONE;
                  if (last_beat) begin
                     wait_cnt <= '0;
                     state    <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (accu_ready) begin
                  res_data         <= accu_res;
                  res_valid[owner] <= 1'b1;
                  state            <= IDLE;
               end else if (wait_cnt == TO_LAST) begin
                  err              <= 1'b1;
                  res_valid[owner] <= 1'b1;
                  state            <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + ONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accu_sched.sv
// Scoreboard bench for accu_sched: behavioural accumulator,
// reference arbiter and per-job sum/latency expectations.
module tb_accu_sched;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int TO = 16;

   typedef struct packed {
      logic [7:0]      jsz;
      logic [1:0]      gaps;
      logic [8*DW-1:0] d;
   } job_t;

   typedef struct packed {
      int            id;
      logic [DW-1:0] data;
      int            ninc;
      int            lat;
      int            t0;
   } exp_t;

   logic               clk;
   logic               rst;
   logic [NR-1:0]      job_valid;
   logic [NR*DW-1:0]   job_size;
   logic [NR-1:0]      job_ready;
   logic [NR-1:0]      in_valid;
   logic [NR*DW-1:0]   in_data;
   logic [NR-1:0]      in_ready;
   logic [DW-1:0]      accu_size;
   logic               accu_inc;
   logic [DW-1:0]      accu_array;
   logic [DW-1:0]      accu_res;
   logic               accu_ready;
   logic [NR-1:0]      res_valid;
   logic [DW-1:0]      res_data;
   logic               busy;
   logic               err;

   accu_sched #(
      .NUM_REQ   (NR),
      .DATA_WIDTH(DW),
      .TIMEOUT   (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .job_valid (job_valid),
      .job_size  (job_size),
      .job_ready (job_ready),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .accu_size (accu_size),
      .accu_inc  (accu_inc),
      .accu_array(accu_array),
      .accu_res  (accu_res),
      .accu_ready(accu_ready),
      .res_valid (res_valid),
      .res_data  (res_data),
      .busy      (busy),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Accumulator: sums inc beats, pulses ready the cycle after the last.
   bit            hang;
   logic [DW-1:0] a_cnt;
   logic [DW-1:0] a_sum;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_cnt      <= '0;
         a_sum      <= '0;
         accu_ready <= 1'b0;
         accu_res   <= '0;
      end else begin
         accu_ready <= 1'b0;
         if (accu_inc) begin
            if (a_cnt + 1 == accu_size) begin
               a_cnt <= '0;
               a_sum <= '0;
               if (!hang) begin
                  accu_ready <= 1'b1;
                  accu_res   <= a_sum + accu_array;
               end
            end else begin
               a_cnt <= a_cnt + 1;
               a_sum <= a_sum + accu_array;
            end
         end
      end
   end

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   job_t pend[NR][$];
   int   glog[$];
   bit   s_active;
   int   s_id;
   job_t s_job;
   int   s_k;
   bit   tog;
   bit   noise;
   int   mptr;

   task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   function automatic logic [8*DW-1:0] rand_words();
      logic [8*DW-1:0] d;
      for (int k = 0; k < 8; k++) d[k*DW +: DW] = $urandom;
      return d;
   endfunction

   function automatic logic [8*DW-1:0] one_word(logic [DW-1:0] x);
      logic [8*DW-1:0] d;
      d = '0;
      d[DW-1:0] = x;
      return d;
   endfunction

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         job_valid[i] = (pend[i].size() != 0);
         if (pend[i].size() != 0) job_size[i*DW +: DW] = DW'(pend[i][0].jsz);
         else job_size[i*DW +: DW] = $urandom;
         in_valid[i] = noise ? 1'($urandom % 2) : 1'b0;
         in_data[i*DW +: DW] = $urandom;
      end
      if (s_active) begin
         case (s_job.gaps)
            2'd0:    in_valid[s_id] = 1'b1;
            2'd1:    in_valid[s_id] = tog;
            default: in_valid[s_id] = 1'($urandom % 2);
         endcase
         in_data[s_id*DW +: DW] = s_job.d[s_k*DW +: DW];
      end
   endtask

   task automatic post(int id, int n, int gaps, logic [8*DW-1:0] d);
      job_t j;
      j.jsz  = 8'(n);
      j.gaps = 2'(gaps);
      j.d    = d;
      pend[id].push_back(j);
      drive();
   endtask

   task automatic observe();
      logic [NR-1:0] acc;
      int   w;
      int   g;
      job_t j;
      exp_t e;
      acc = job_ready & job_valid;
      if (acc != '0) begin
         w = -1;
         for (int k = 1; k <= NR; k++) begin
            if (w < 0 && job_valid[(mptr + k) % NR]) w = (mptr + k) % NR;
         end
         chk("grant", DW'(job_ready), DW'(1 << w));
         g = 0;
         for (int i = NR - 1; i >= 0; i--) if (acc[i]) g = i;
         mptr = g;
         glog.push_back(g);
         j = pend[g].pop_front();
         e.id   = g;
         e.ninc = int'(j.jsz);
         e.t0   = cyc;
         e.data = '0;
         for (int k = 0; k < int'(j.jsz); k++) e.data = e.data + j.d[k*DW +: DW];
         if (hang) e.data = '0;
         if (j.gaps != 0) e.lat = -1;
         else if (j.jsz == 0) e.lat = 1;
         else if (hang) e.lat = int'(j.jsz) + 1 + TO;
         else e.lat = int'(j.jsz) + 2;
         exp_q.push_back(e);
         if (j.jsz != 0) begin
            s_active = 1'b1;
            s_id     = g;
            s_job    = j;
            s_k      = 0;
         end
      end else if (s_active && in_valid[s_id] && in_ready[s_id]) begin
         chk("in_ready", DW'(in_ready), DW'(1 << s_id));
         chk("accu_inc", DW'(accu_inc), DW'(1));
         chk("accu_array", accu_array, s_job.d[s_k*DW +: DW]);
         chk("accu_size", accu_size, DW'(s_job.jsz));
         s_k++;
         if (s_k == int'(s_job.jsz)) s_active = 1'b0;
      end
      tog = ~tog;
   endtask

   task automatic step();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
      drive();
   endtask

   function automatic bit all_idle();
      bit ok;
      ok = !s_active && (exp_q.size() == 0);
      for (int i = 0; i < NR; i++) if (pend[i].size() != 0) ok = 1'b0;
      return ok;
   endfunction

   task automatic wait_idle(int max);
      int n;
      n = 0;
      while (n < max && !all_idle()) begin
         step();
         n++;
      end
      chk("drain", DW'(all_idle()), DW'(1));
   endtask

   // Monitor: pops one expectation per result pulse.
   initial begin
      exp_t e;
      int   inc_cnt;
      inc_cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            inc_cnt = 0;
         end else begin
            if (accu_inc) inc_cnt++;
            if (res_valid != '0) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_res", DW'(res_valid), DW'(0));
               end else begin
                  e = exp_q.pop_front();
                  chk("res_owner", DW'(res_valid), DW'(1 << e.id));
                  chk("res_data", res_data, e.data);
                  chk("inc_count", DW'(inc_cnt), DW'(e.ninc));
                  if (e.lat != -1) chk("latency", DW'(cyc - e.t0), DW'(e.lat));
                  inc_cnt = 0;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8*DW-1:0] d;
      int eo[5];
      int n;
      int posted;
      eo = '{0, 1, 2, 3, 0};
      rst      = 1'b1;
      hang     = 1'b0;
      noise    = 1'b0;
      tog      = 1'b0;
      s_active = 1'b0;
      s_id     = 0;
      s_k      = 0;
      s_job    = '0;
      mptr     = NR - 1;
      for (int i = 0; i < NR; i++) post(i, 1, 0, one_word(DW'(i + 1)));
      post(0, 1, 0, one_word(DW'(1)));
      #2 rst = 1'b0;
      #1;
      chk("rst_job_ready", DW'(job_ready), DW'(0));
      chk("rst_in_ready", DW'(in_ready), DW'(0));
      chk("rst_res_valid", DW'(res_valid), DW'(0));
      chk("rst_accu_inc", DW'(accu_inc), DW'(0));
      chk("rst_accu_size", accu_size, DW'(0));
      chk("rst_accu_array", accu_array, DW'(0));
      chk("rst_res_data", res_data, DW'(0));
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_err", DW'(err), DW'(0));
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      drive();
      wait_idle(200);
      chk("grant_cnt", DW'(glog.size()), DW'(5));
      for (int k = 0; k < 5; k++) begin
         if (k < glog.size()) chk("grant_order", DW'(glog[k]), DW'(eo[k]));
      end

      d = '0;
      d[0 +: DW]    = 5;
      d[DW +: DW]   = 7;
      d[2*DW +: DW] = 9;
      post(1, 3, 0, d);
      wait_idle(50);

      glog.delete();
      post(2, 0, 0, '0);
      n = 0;
      while (glog.size() == 0 && n < 20) begin
         step();
         n++;
      end
      chk("zero_grant", DW'(glog.size()), DW'(1));
      chk("zero_busy", DW'(busy), DW'(0));
      wait_idle(20);

      noise = 1'b1;
      post(0, 4, 1, rand_words());
      wait_idle(100);

      hang = 1'b1;
      post(3, 2, 0, rand_words());
      wait_idle(100);
      chk("err_set", DW'(err), DW'(1));
      hang = 1'b0;
      post(1, 2, 0, rand_words());
      wait_idle(50);
      chk("err_sticky", DW'(err), DW'(1));

      posted = 0;
      n = 0;
      while (posted < 40 && n < 3000) begin
         for (int i = 0; i < NR; i++) begin
            if (pend[i].size() == 0 && posted < 40 && $urandom_range(0, 2) == 0) begin
               post(i, $urandom_range(0, 5), $urandom_range(0, 2), rand_words());
               posted++;
            end
         end
         step();
         n++;
      end
      wait_idle(1000);
      chk("err_still", DW'(err), DW'(1));

      noise = 1'b0;
      post(2, 5, 0, rand_words());
      n = 0;
      while (!s_active && n < 20) begin
         step();
         n++;
      end
      chk("mid_grant", DW'(s_active), DW'(1));
      step();
      step();
      chk("mid_busy", DW'(busy), DW'(1));
      rst = 1'b0;
      #1;
      chk("mid_busy_drop", DW'(busy), DW'(0));
      chk("mid_in_ready", DW'(in_ready), DW'(0));
      chk("mid_accu_inc", DW'(accu_inc), DW'(0));
      chk("mid_res_valid", DW'(res_valid), DW'(0));
      chk("mid_err_clr", DW'(err), DW'(0));
      exp_q.delete();
      s_active = 1'b0;
      mptr = NR - 1;
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      drive();
      repeat (10) step();
      glog.delete();
      post(3, 2, 0, rand_words());
      wait_idle(50);
      chk("post_rst_grant", DW'(glog.size()), DW'(1));
      chk("post_rst_err", DW'(err), DW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/accu_sched.md
# accu_sched

Round-robin job scheduler that shares one pipelined number accumulator (size/inc/array in, res/ready out) between NUM_REQ requesters. It accepts a job descriptor from a requester and streams that requester's words into the accumulator. It then captures the sum and returns it to the owning requester. It sits between the per-requester read streams and the accumulator, and handles the zero-size and hung-accumulator cases that the accumulator itself cannot.

## Interface
- NUM_REQ, default 4: number of requesters; must be ≥ 2.
- DATA_WIDTH, default 32: word, size and result width.
- TIMEOUT, default 16: maximum number of WAIT cycles allowed for accu_ready.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- job_valid  in  NUM_REQ  per-requester job request.
- job_size  in  NUM_REQ*DATA_WIDTH  per-requester word count; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- job_ready  out  NUM_REQ  one-hot; a job is accepted in any cycle where job_valid[i] and job_ready[i] are both high.
- in_valid  in  NUM_REQ  per-requester data beat valid.
- in_data  in  NUM_REQ*DATA_WIDTH  per-requester data word, same slicing as job_size.
- in_ready  out  NUM_REQ  one-hot; high only for the owner while in RUN.
- accu_size  out  DATA_WIDTH  drives the accumulator's size input.
- accu_inc  out  1  drives the accumulator's inc input.
- accu_array  out  DATA_WIDTH  drives the accumulator's array input.
- accu_res  in  DATA_WIDTH  accumulator result.
- accu_ready  in  1  accumulator result-valid pulse.
- res_valid  out  NUM_REQ  one-hot, single-cycle pulse to the owner.
- res_data  out  DATA_WIDTH  result; valid only while res_valid is nonzero.
- busy  out  1  high when state is not IDLE.
- err  out  1  sticky timeout flag; cleared only by reset.

## Operation
- FSM states: IDLE, RUN, WAIT.
- IDLE, arbitration:
  - Among requesters with job_valid set, pick the first one found searching from ptr+1 upward, modulo NUM_REQ.
  - job_ready[winner] is combinational and goes high in the same cycle.
  - On acceptance, ptr becomes the winner.
  - Reset value of ptr is NUM_REQ-1, so requester 0 has highest priority after reset.
- IDLE, accepted job with size ≥ 1:
  - Latch owner and size into registers.
  - Clear sent_cnt.
  - Go to RUN.
- IDLE, accepted job with size 0:
  - The accumulator is never touched; its count compare would wrap.
  - Pulse res_valid[winner] in the next cycle with res_data = 0.
  - Stay in IDLE.
- RUN:
  - in_ready[owner] = 1.
  - On each accepted beat (in_valid[owner] high), drive accu_inc = 1 with accu_array = in_data[owner] in the same cycle, combinationally, and increment sent_cnt.
  - The beat where sent_cnt == size-1 is the last beat; go to WAIT after it.
  - in_ready is 0 in the WAIT cycle.
- WAIT:
  - When accu_ready is sampled high: register accu_res into res_data, set res_valid[owner] for the next cycle, go to IDLE.
  - A wait counter increments on every WAIT cycle. When it reaches TIMEOUT without accu_ready: set err, pulse res_valid[owner] with res_data = 0, go to IDLE.
- accu_size always equals the latched size register. It changes only at job acceptance and is held through RUN and WAIT.
- Outside RUN, accu_inc = 0 and accu_array = 0.
- Non-owners see in_ready = 0 at all times, and their in_valid is ignored.
- A requester's job_valid may stay high across its own completed job. Fairness comes only from the pointer.
- sent_cnt and the wait counter are DATA_WIDTH bits wide. No arithmetic overflow is possible, because the compare uses the latched size.
- res_valid and the job_ready of a new acceptance may be high in the same cycle.

## Timing
- Full job of N words, with job_ready at cycle C0 and in_valid held high:
  - Beats occur at C1..CN.
  - The accumulator asserts ready at CN+1, which is sampled in WAIT.
  - res_valid is high at CN+2, and the FSM is in IDLE at CN+2.
  - The next job can be accepted at CN+2.
- Job latency is therefore N+2 cycles from acceptance to result.
- Zero-size job: res_valid appears one cycle after acceptance, and the next acceptance can happen in that same cycle.
- in_valid gaps during RUN stall the job with no limit. The timeout covers WAIT only.
- Reset asserted (rst low) at any time:
  - Asynchronously forces IDLE, ptr = NUM_REQ-1, counters = 0, err = 0.
  - All outputs read 0 while rst is low, including the combinational job_ready, in_ready and accu_inc, which are gated by rst.
  - A job in progress is dropped with no res_valid.
  - The accumulator must be reset alongside this block.
- Reset deassertion is synchronous to clk at the system level.

## Test plan
- Reset with job_valid = 4'b1111: job_ready = 0 and all other outputs = 0. After release, the first grant goes to requester 0.
- Requester 1, size 3, data 5, 7, 9 streamed back-to-back: accu_inc is high for 3 cycles, accu_size = 3, res_valid = 4'b0010 with res_data = 21 at acceptance+5.
- All requesters valid with size 1 and data = id+1: grant order is 0, 1, 2, 3, 0. Results are 1, 2, 3, 4, one per requester.
- Requester 2, size 0: no accu_inc. res_valid = 4'b0100 with res_data = 0 one cycle after acceptance; busy stays 0.
- Requester 0, size 4, with in_valid toggling every other cycle: exactly 4 accu_inc pulses, and res_data is the correct sum. Non-owner in_valid pulses are ignored.
- Accumulator model holds ready low with TIMEOUT = 16: WAIT lasts 16 cycles, then err = 1 and res_valid for the owner with res_data = 0. err stays 1 across later jobs until reset. A separate run asserts reset mid-RUN: busy drops immediately and no res_valid is produced.
